// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg
//
// Elastic pipeline stage with a two-entry skid buffer. Data moves forward
// through a main register (the head entry, driving out_data). A skid register
// catches one extra beat, so upstream can keep pushing for a cycle after
// downstream stalls. in_ready comes from internal state, flush and reset
// only. It never depends on out_ready, so this stage breaks the backward
// combinational ready path.
//
// Parameters:
//   WIDTH        data width in bits
//   RESET_VALUE  value of both buffer entries (and out_data) after reset/flush
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset (priority over everything)
//   flush      synchronous drop of all buffered entries
//   in_valid   upstream data valid
//   in_ready   stage can accept upstream data this cycle
//   in_data    upstream data
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head entry (main register)
//   occupancy  number of valid entries, 0..2 (registered)

module pipeline_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // in_ready goes low as soon as flush or reset is raised. Only the
  // registered state qualifies it otherwise, so out_ready never reaches it.
  assign in_ready = (state != ST_FULL) & ~flush & ~reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: both data entries are reset, not just the valid state, so
      // out_data shows RESET_VALUE instead of X until the first load.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
    end else if (flush) begin
      // If out_fire happens in the flush cycle, downstream has already taken
      // the head entry. Dropping everything here is therefore correct.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q    <= in_data;
            state     <= ST_BUSY;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end

        ST_BUSY: begin
          if (in_fire && out_fire) begin
            // Head leaves while a new beat arrives. The new beat becomes the
            // head directly, and the skid register is not used.
            main_q <= in_data;
          end else if (in_fire) begin
            // Downstream stalled. Park the younger beat in the skid register.
            skid_q    <= in_data;
            state     <= ST_FULL;
            occupancy <= 2'd2;
          end else if (out_fire) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the output side can make progress.
          if (out_fire) begin
            main_q    <= skid_q;
            state     <= ST_BUSY;
            occupancy <= 2'd1;
          end
        end

        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
          main_q    <= RESET_VALUE;
          skid_q    <= RESET_VALUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// tb_pipeline_skid_reg
//
// Directed testbench for pipeline_skid_reg. Each scenario task drives its own
// stimulus and compares DUT outputs with hand-computed values. The soak task
// tracks accepted beats in a queue, which serves as the reference for order,
// occupancy and readiness.
//
// Timing: inputs are driven and registered outputs are sampled 1 ns after the
// rising edge. in_ready is sampled 1 ns after the inputs change.

module tb_pipeline_skid_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks_total;
  int checks_passed;

  pipeline_skid_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    #1;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    else checks_passed++;
    tick();
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else checks_passed++;
    checks_total++;
    if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    else checks_passed++;
    checks_total++;
    if (out_data !== RV) $display("FAIL reset_out_data: got %h want %h", out_data, RV);
    else checks_passed++;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    else checks_passed++;
  endtask

  task automatic test_pass_through();
    logic [31:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      #1;
      checks_total++;
      if (in_ready !== 1'b1) $display("FAIL pass_in_ready[%0d]: got %b want 1", i, in_ready);
      else checks_passed++;
      tick();
      checks_total++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1)
        $display("FAIL pass_out[%0d]: got v=%b d=%h occ=%0d want v=1 d=%h occ=1",
                 i, out_valid, out_data, occupancy, vals[i]);
      else checks_passed++;
    end
    in_valid = 1'b0;
    tick();
    checks_total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL pass_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    checks_total++;
    if (occupancy !== 2'd2 || out_data !== 32'hA || out_valid !== 1'b1)
      $display("FAIL bp_full: got occ=%0d d=%h v=%b want occ=2 d=a v=1", occupancy, out_data, out_valid);
    else checks_passed++;
    in_data = 32'hC;
    #1;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
    else checks_passed++;
    tick();
    checks_total++;
    if (occupancy !== 2'd2 || out_data !== 32'hA)
      $display("FAIL bp_hold: got occ=%0d d=%h want occ=2 d=a", occupancy, out_data);
    else checks_passed++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks_total++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || occupancy !== 2'd1)
      $display("FAIL bp_second: got v=%b d=%h occ=%0d want v=1 d=b occ=1", out_valid, out_data, occupancy);
    else checks_passed++;
    tick();
    checks_total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL bp_drained: got v=%b occ=%0d want v=0 occ=0 (0xC must not be taken)", out_valid, occupancy);
    else checks_passed++;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    checks_total++;
    if (out_data !== 32'h5 || occupancy !== 2'd1)
      $display("FAIL sim_load: got d=%h occ=%0d want d=5 occ=1", out_data, occupancy);
    else checks_passed++;
    in_data   = 32'h6;
    out_ready = 1'b1;
    tick();
    checks_total++;
    if (out_data !== 32'h6 || occupancy !== 2'd1 || out_valid !== 1'b1)
      $display("FAIL sim_swap: got d=%h occ=%0d v=%b want d=6 occ=1 v=1", out_data, occupancy, out_valid);
    else checks_passed++;
    in_valid = 1'b0;
    tick();
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL sim_drain: got v=%b want 0", out_valid);
    else checks_passed++;
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    flush   = 1'b1;
    in_data = 32'h33;
    #1;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready);
    else checks_passed++;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks_total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV)
      $display("FAIL flush_state: got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", out_valid, occupancy, out_data, RV);
    else checks_passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks_total++;
      if (out_valid !== 1'b0 || out_data === 32'h33)
        $display("FAIL flush_no_leak[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    checks_total++;
    if (occupancy !== 2'd2) $display("FAIL rst_mid_fill: got occ=%0d want 2", occupancy);
    else checks_passed++;
    reset     = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h66;
    #1;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b want 0", in_ready);
    else checks_passed++;
    tick();
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready_hold: got %b want 0", in_ready);
    else checks_passed++;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks_total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV || in_ready !== 1'b1)
      $display("FAIL rst_mid_release: got v=%b occ=%0d d=%h rdy=%b want v=0 occ=0 d=%h rdy=1",
               out_valid, occupancy, out_data, in_ready, RV);
    else checks_passed++;
  endtask

  // Random valid/ready soak. The queue holds accepted beats that have not
  // yet been delivered, in arrival order.
  task automatic test_soak();
    logic [31:0] q[$];
    logic [31:0] next_data;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        ready_a;
    logic        exp_ready;
    bit          in_fire_m;
    bit          out_fire_m;
    next_data  = 32'h100;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks_total++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() != 0))
        $display("FAIL soak_occ[%0d]: got occ=%0d v=%b want occ=%0d", cyc, occupancy, out_valid, q.size());
      else checks_passed++;
      if (q.size() != 0) begin
        checks_total++;
        if (out_data !== q[0]) $display("FAIL soak_order[%0d]: got %h want %h", cyc, out_data, q[0]);
        else checks_passed++;
      end
      if (prev_stall) begin
        checks_total++;
        if (out_data !== prev_data || out_valid !== 1'b1)
          $display("FAIL soak_stable[%0d]: got d=%h v=%b want d=%h v=1", cyc, out_data, out_valid, prev_data);
        else checks_passed++;
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (cyc % 500 < 100) out_ready = 1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1));
      in_data   = next_data;
      exp_ready = (q.size() < 2);
      #1;
      ready_a = in_ready;
      out_ready = ~out_ready;
      #1;
      checks_total++;
      if (ready_a !== exp_ready || in_ready !== ready_a)
        $display("FAIL soak_in_ready[%0d]: got %b/%b want %b", cyc, ready_a, in_ready, exp_ready);
      else checks_passed++;
      out_ready = ~out_ready;
      in_fire_m  = in_valid && exp_ready;
      out_fire_m = out_ready && (q.size() != 0);
      prev_stall = (q.size() != 0) && !out_ready;
      prev_data  = (q.size() != 0) ? q[0] : '0;
      if (out_fire_m) void'(q.pop_front());
      if (in_fire_m) begin
        q.push_back(next_data);
        next_data++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    test_reset();
    tick();
    test_pass_through();
    test_backpressure();
    test_simultaneous();
    test_flush_full();
    test_reset_mid_stream();
    tick();
    test_soak();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
